// File: rtl/regfile_pkg.sv
// Shared constants, FSM state encoding and LFSR step function for the
// register-file BIST engine.
package regfile_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [2:0] {
        IDLE,
        WR_INC,
        RD_A1,
        WR_RND,
        RD_A2,
        DONE
    } state_t;

    // Galois right shift; the mask keeps a nonzero state nonzero.
    function automatic logic [31:0] lfsr_step(input logic [31:0] q);
        logic [31:0] shifted;
        shifted = q >> 1;
        return q[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

endpackage

// File: rtl/regfile_bist_lfsr.sv
// 32-bit Galois LFSR with synchronous load, used to generate and replay
// the pseudo-random write pattern.
module bist_lfsr
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        en,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    // NOTE: clocked state uses non-blocking assignments so every flop
    // samples its inputs as they were before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 32'h0000_0001;
        end else if (load) begin
            state <= seed;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/regfile_bist.sv
// March-style self-test for a 32x32 register file: incrementing and random
// write passes, each verified through one read port, with first-failure capture.
module regfile_bist #(
    parameter int          ADDR_W = 5,
    parameter int          DATA_W = 32,
    parameter int          NREGS  = 32,
    parameter logic [31:0] SEED   = 32'h0000_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [6:0]        err_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_port,
    output logic [DATA_W-1:0] fail_got,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_a1,
    output logic [ADDR_W-1:0] rf_a2,
    output logic [ADDR_W-1:0] rf_a3,
    output logic [DATA_W-1:0] rf_wd3,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2
);

    import regfile_pkg::*;

    localparam logic [DATA_W-1:0] SEED_EFF = (SEED == 32'h0) ? DATA_W'(1) : DATA_W'(SEED);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NREGS - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx, idx_nxt;
    logic                idx_last;

    logic                we_nxt;
    logic [ADDR_W-1:0]   a1_nxt, a2_nxt, a3_nxt;
    logic [DATA_W-1:0]   wd3_nxt;

    logic                lfsr_load, lfsr_en;
    logic [DATA_W-1:0]   lfsr_q;

    logic                chk_en, chk_port, mismatch;
    logic [DATA_W-1:0]   chk_got, chk_exp;

    assign idx_last = (idx == IDX_LAST);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // NOTE: every signal assigned in an always_comb gets a default first,
    // so no path through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        idx_nxt   = '0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = WR_INC;
            end
            WR_INC, RD_A1, WR_RND, RD_A2: begin
                idx_nxt = idx + 1'b1;
                if (idx_last) begin
                    unique case (state)
                        WR_INC:  state_nxt = RD_A1;
                        RD_A1:   state_nxt = WR_RND;
                        WR_RND:  state_nxt = RD_A2;
                        default: state_nxt = DONE;
                    endcase
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The LFSR holds the value for the current index; it is reloaded on entry
    // to each random phase so the read pass replays the write pass.
    assign lfsr_load = ((state_nxt == WR_RND) && (state != WR_RND)) ||
                       ((state_nxt == RD_A2)  && (state != RD_A2));
    assign lfsr_en   = (state == WR_RND) || (state == RD_A2);

    bist_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .en    (lfsr_en),
        .seed  (SEED_EFF),
        .state (lfsr_q)
    );

    // Register-file port values for the coming cycle, decoded from the next state.
    always_comb begin
        we_nxt  = (state_nxt == WR_INC) || (state_nxt == WR_RND);
        a1_nxt  = (state_nxt == RD_A1) ? idx_nxt : '0;
        a2_nxt  = (state_nxt == RD_A2) ? idx_nxt : '0;
        a3_nxt  = we_nxt ? idx_nxt : '0;
        wd3_nxt = '0;
        if (state_nxt == WR_INC) begin
            wd3_nxt = DATA_W'(idx_nxt) + DATA_W'(1);
        end else if (state_nxt == WR_RND) begin
            wd3_nxt = lfsr_load ? SEED_EFF : lfsr_step(lfsr_q);
        end
    end

    always_comb begin
        chk_en   = 1'b0;
        chk_port = 1'b0;
        chk_got  = '0;
        chk_exp  = '0;
        if (state == RD_A1) begin
            chk_en  = 1'b1;
            chk_got = rf_rd1;
            chk_exp = (idx == '0) ? '0 : DATA_W'(idx) + DATA_W'(1);
        end else if (state == RD_A2) begin
            chk_en   = 1'b1;
            chk_port = 1'b1;
            chk_got  = rf_rd2;
            chk_exp  = (idx == '0) ? '0 : lfsr_q;
        end
    end

    assign mismatch = chk_en && (chk_got != chk_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            rf_we  <= 1'b0;
            rf_a1  <= '0;
            rf_a2  <= '0;
            rf_a3  <= '0;
            rf_wd3 <= '0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            rf_we  <= we_nxt;
            rf_a1  <= a1_nxt;
            rf_a2  <= a2_nxt;
            rf_a3  <= a3_nxt;
            rf_wd3 <= wd3_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            fail_got  <= '0;
        end else if ((state == IDLE) && start) begin
            pass      <= 1'b0;
            err_cnt   <= '0;
            fail_addr <= '0;
            fail_port <= 1'b0;
            fail_got  <= '0;
        end else begin
            if (mismatch) begin
                if (err_cnt == '0) begin
                    fail_addr <= idx;
                    fail_port <= chk_port;
                    fail_got  <= chk_got;
                end
                if (err_cnt != 7'd127) err_cnt <= err_cnt + 7'd1;
            end
            // Verdict lands as DONE is entered, including a miss on the last read.
            if ((state == RD_A2) && idx_last) pass <= (err_cnt == '0) && !mismatch;
        end
    end

endmodule
